// File: rtl/ram_arbiter_if.sv
// Two-requester RAM access bus: a CPU port (p0) and a debug/DMA port (p1).
// The arbiter sits on the slave side; the requesters drive the master side.
interface ram_arbiter_if;
  logic        p0_valid;
  logic        p0_ready;
  logic        p0_we;
  logic [7:0]  p0_addr;
  logic [63:0] p0_wdata;
  logic        p0_rsp_valid;
  logic [63:0] p0_rdata;

  logic        p1_valid;
  logic        p1_ready;
  logic        p1_we;
  logic [7:0]  p1_addr;
  logic [63:0] p1_wdata;
  logic        p1_rsp_valid;
  logic [63:0] p1_rdata;

  modport master (
    output p0_valid, p0_we, p0_addr, p0_wdata,
    input  p0_ready, p0_rsp_valid, p0_rdata,
    output p1_valid, p1_we, p1_addr, p1_wdata,
    input  p1_ready, p1_rsp_valid, p1_rdata
  );

  modport slave (
    input  p0_valid, p0_we, p0_addr, p0_wdata,
    output p0_ready, p0_rsp_valid, p0_rdata,
    input  p1_valid, p1_we, p1_addr, p1_wdata,
    output p1_ready, p1_rsp_valid, p1_rdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter in front of a single-port 256x64 RAM.
// After reset the RAM is optionally zero-filled (CLEAR) before requests are
// served (RUN). Writes to word 0xFF are also mirrored out as an io pulse.
//
// state    | meaning
// ST_CLEAR | sweeping zeros through the RAM, both ready outputs held low
// ST_RUN   | arbitrating and serving p0/p1 requests
module ram_arbiter #(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  ram_arbiter_if.slave bus,
  output logic        io_write,
  output logic [63:0] io_data,
  output logic        busy,
  output logic [15:0] conflict_cnt
);

  localparam logic [7:0] IO_ADDR = 8'hFF;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t      state_q;
  logic [7:0]  sweep_q;
  logic        prio_q;
  logic        busy_q;
  logic [15:0] cnt_q;
  logic        rsp0_q, rsp1_q;
  logic [63:0] rd0_q, rd1_q;
  logic        io_write_q;
  logic [63:0] io_data_q;
  logic [63:0] ram_q [256];

  logic        run;
  logic        gnt0, gnt1;
  logic        acc_we;
  logic [7:0]  acc_addr;
  logic [63:0] acc_wdata;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [63:0] mem_wdata;

  // Grant logic is combinational so a lone requester is accepted in the same cycle.
  always_comb begin
    run       = (state_q == ST_RUN) && !rst;
    gnt0      = run && bus.p0_valid && (!bus.p1_valid || !prio_q);
    gnt1      = run && bus.p1_valid && (!bus.p0_valid || prio_q);
    acc_we    = gnt1 ? bus.p1_we    : bus.p0_we;
    acc_addr  = gnt1 ? bus.p1_addr  : bus.p0_addr;
    acc_wdata = gnt1 ? bus.p1_wdata : bus.p0_wdata;
    mem_we    = 1'b0;
    mem_addr  = acc_addr;
    mem_wdata = acc_wdata;
    if (!rst) begin
      if (state_q == ST_CLEAR) begin
        mem_we    = 1'b1;
        mem_addr  = sweep_q;
        mem_wdata = 64'd0;
      end else begin
        mem_we = (gnt0 || gnt1) && acc_we;
      end
    end
  end

  // Single RAM write port shared by the clear sweep and accepted writes.
  always_ff @(posedge clk) begin
    if (mem_we) ram_q[mem_addr] <= mem_wdata;
  end

  // Sequencer, arbitration pointer, read responses, io mirror and conflict counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      sweep_q    <= 8'd0;
      busy_q     <= CLEAR_ON_RESET;
      prio_q     <= 1'b0;
      cnt_q      <= 16'd0;
      rsp0_q     <= 1'b0;
      rsp1_q     <= 1'b0;
      rd0_q      <= 64'd0;
      rd1_q      <= 64'd0;
      io_write_q <= 1'b0;
      io_data_q  <= 64'd0;
    end else begin
      rsp0_q     <= 1'b0;
      rsp1_q     <= 1'b0;
      io_write_q <= 1'b0;
      io_data_q  <= 64'd0;
      case (state_q)
        ST_CLEAR: begin
          sweep_q <= sweep_q + 8'd1;
          if (sweep_q == 8'hFF) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          // A write in the previous cycle is already in the RAM, so reads see it.
          if (gnt0 && !bus.p0_we) begin
            rsp0_q <= 1'b1;
            rd0_q  <= ram_q[bus.p0_addr];
          end
          if (gnt1 && !bus.p1_we) begin
            rsp1_q <= 1'b1;
            rd1_q  <= ram_q[bus.p1_addr];
          end
          if ((gnt0 || gnt1) && acc_we && (acc_addr == IO_ADDR)) begin
            io_write_q <= 1'b1;
            io_data_q  <= acc_wdata;
          end
          if (gnt0) prio_q <= 1'b1;
          else if (gnt1) prio_q <= 1'b0;
          if (bus.p0_valid && bus.p1_valid && (cnt_q != 16'hFFFF))
            cnt_q <= cnt_q + 16'd1;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign bus.p0_ready     = gnt0;
  assign bus.p1_ready     = gnt1;
  assign bus.p0_rsp_valid = rsp0_q;
  assign bus.p1_rsp_valid = rsp1_q;
  assign bus.p0_rdata     = rd0_q;
  assign bus.p1_rdata     = rd1_q;
  assign io_write         = io_write_q;
  assign io_data          = io_data_q;
  assign busy             = busy_q;
  assign conflict_cnt     = cnt_q;

endmodule
